// File: rtl/uart_pkg.sv
// Shared UART definitions: baud presets, frame geometry and TX state encoding.
// The receiver is expected to import this package as well.
package uart_pkg;

  localparam int UART_DELAY_27M_115200 = 234;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO: registered write, combinational head read.
// Full/empty come from the occupancy count; pointers wrap modulo depth.
module byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [7:0]                  i_data,
  input  logic                        i_pop,
  output logic [7:0]                  o_head,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_stream.sv
// Streaming 8N1 transmitter: FIFO-buffered bytes go out as back-to-back
// frames. Line, busy and done are registered from the current FSM state.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = UART_DELAY_27M_115200,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        uart_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        tx_done
);

  localparam int BW = $clog2(DELAY_FRAMES);
  localparam logic [BW-1:0] BAUD_MAX = BW'(DELAY_FRAMES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  tx_state_e     r_state;
  tx_state_e     w_state_n;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_n;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_n;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_n;
  logic          r_tx;
  logic          r_done;
  logic          r_busy;
  logic          w_line;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign in_ready  = !w_full && !rst;
  assign w_push    = in_valid && in_ready;
  assign w_bit_end = (r_baud == BAUD_MAX);
  assign uart_tx   = r_tx;
  assign tx_done   = r_done;
  assign busy      = r_busy;

  byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (w_push),
    .i_data (in_data),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_count(fifo_count),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + BW'(1);
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_line    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_baud_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_idx_n   = '0;
          w_state_n = START;
        end
      end
      START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_baud_n  = '0;
          w_idx_n   = '0;
          w_state_n = DATA;
        end
      end
      DATA: begin
        w_line = r_shift[r_idx];
        if (w_bit_end) begin
          w_baud_n = '0;
          if (r_idx == LAST_BIT) w_state_n = STOP;
          else w_idx_n = r_idx + 3'd1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_n = '0;
          // Chain straight into the next start bit when data is waiting
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_idx_n   = '0;
            w_state_n = START;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_tx    <= w_line;
      r_done  <= (r_state == STOP) && w_bit_end;
      r_busy  <= (r_state != IDLE) || !w_empty;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: accepted bytes feed a queue that a serial
// line decoder drains and compares frame by frame.
module tb_uart_tx_stream;

  localparam int D  = 8;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       tx_done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames = 0;
  int dones = 0;
  int n99 = 0;
  logic [7:0] sb[$];
  int starts[$];

  bit         m_act = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = '0;

  uart_tx_stream #(
    .DELAY_FRAMES(D),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  // Scoreboard producer side: record every accepted byte
  always @(posedge clk) begin
    cyc++;
    if (rst) sb.delete();
    else if (in_valid && in_ready) begin
      sb.push_back(in_data);
      if (in_data == 8'h99) n99++;
    end
  end

  // Line decoder: samples each bit mid-cell and pops the scoreboard
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      m_act = 1'b0;
    end else begin
      if (tx_done === 1'b1) dones++;
      if (!m_act) begin
        if (uart_tx === 1'b0) begin
          m_act = 1'b1;
          m_cnt = 0;
          starts.push_back(cyc);
        end
      end else begin
        m_cnt++;
        for (int j = 0; j < 8; j++)
          if (m_cnt == D * (j + 1) + D / 2) m_byte[j] = uart_tx;
        if (m_cnt == D / 2) begin
          checks++;
          if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL start_bit: got %b want 0", uart_tx);
          end
        end
        if (m_cnt == 9 * D + D / 2) begin
          checks++;
          if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit: got %b want 1", uart_tx);
          end
        end
        if (m_cnt == 10 * D - 1) begin
          m_act = 1'b0;
          frames++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_byte: got %h want none queued", m_byte);
          end else begin
            e = sb.pop_front();
            if (m_byte !== e) begin
              errors++;
              $display("FAIL frame_byte: got %h want %h", m_byte, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present a byte from a negedge and hold it until accepted; -1 on timeout
  task automatic push_byte(input logic [7:0] b, output int acc);
    bit ok;
    acc = -1;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) begin
        acc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle(output int t);
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      checks += 4;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
      end
      if (uart_tx !== 1'b1) begin
        errors++; $display("FAIL rst_uart_tx: got %b want 1", uart_tx);
      end
      if (fifo_count !== 3'd0) begin
        errors++; $display("FAIL rst_count: got %0d want 0", fifo_count);
      end
      if (busy !== 1'b0) begin
        errors++; $display("FAIL rst_busy: got %b want 0", busy);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single;
    logic [7:0] b;
    int e0, d0, f0, t;
    logic ex_tx, ex_done, ex_busy;
    b  = 8'h4C;
    d0 = dones;
    f0 = frames;
    push_byte(b, e0);
    in_valid = 1'b0;
    checks++;
    if (e0 < 0) begin
      errors++; $display("FAIL single_accept: got timeout want accept");
    end
    checks++;
    if (fifo_count !== 3'd1) begin
      errors++; $display("FAIL single_count0: got %0d want 1", fifo_count);
    end
    for (int k = 1; k <= 84; k++) begin
      @(negedge clk);
      ex_tx = 1'b1;
      if (k >= 2 && k <= 9) ex_tx = 1'b0;
      else if (k >= 10 && k <= 73) ex_tx = b[(k - 10) / 8];
      ex_done = (k == 81);
      ex_busy = (k >= 1 && k <= 81);
      checks += 3;
      if (uart_tx !== ex_tx) begin
        errors++; $display("FAIL single_tx k=%0d: got %b want %b", k, uart_tx, ex_tx);
      end
      if (tx_done !== ex_done) begin
        errors++; $display("FAIL single_done k=%0d: got %b want %b", k, tx_done, ex_done);
      end
      if (busy !== ex_busy) begin
        errors++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, ex_busy);
      end
      if (k == 1) begin
        checks++;
        if (fifo_count !== 3'd0) begin
          errors++; $display("FAIL single_count1: got %0d want 0", fifo_count);
        end
      end
    end
    wait_idle(t);
    checks += 3;
    if (frames - f0 != 1) begin
      errors++; $display("FAIL single_frames: got %0d want 1", frames - f0);
    end
    if (dones - d0 != 1) begin
      errors++; $display("FAIL single_dones: got %0d want 1", dones - d0);
    end
    if (sb.size() != 0) begin
      errors++; $display("FAIL single_sb: got %0d left want 0", sb.size());
    end
  endtask

  task automatic test_burst;
    int acc[6];
    int t, d0;
    d0 = dones;
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      push_byte(8'h61 + 8'(i), acc[i]);
      if (i == 4) begin
        checks += 2;
        if (fifo_count !== 3'd4) begin
          errors++; $display("FAIL burst_full_count: got %0d want 4", fifo_count);
        end
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL burst_full_ready: got %b want 0", in_ready);
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (acc[i] != acc[0] + i) begin
        errors++; $display("FAIL burst_accept%0d: got %0d want %0d", i, acc[i], acc[0] + i);
      end
    end
    checks++;
    if (acc[5] != acc[0] + 82) begin
      errors++; $display("FAIL burst_reaccept: got %0d want %0d", acc[5], acc[0] + 82);
    end
    wait_idle(t);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL burst_idle_timeout: got busy=%b want 0", busy);
    end
    checks += 3;
    if (starts.size() != 6) begin
      errors++; $display("FAIL burst_nframes: got %0d want 6", starts.size());
    end else begin
      if (starts[0] != acc[0] + 2) begin
        errors++; $display("FAIL burst_first_start: got %0d want %0d", starts[0], acc[0] + 2);
      end
      for (int i = 1; i < 6; i++) begin
        checks++;
        if (starts[i] - starts[i - 1] != 10 * D) begin
          errors++;
          $display("FAIL burst_gap%0d: got %0d want %0d", i, starts[i] - starts[i - 1], 10 * D);
        end
      end
    end
    if (dones - d0 != 6) begin
      errors++; $display("FAIL burst_dones: got %0d want 6", dones - d0);
    end
  endtask

  task automatic test_reset_midframe;
    int e0, a1, a2, d0, f0, lows, t;
    wait_idle(t);
    push_byte(8'hA5, e0);
    push_byte(8'h3C, a1);
    push_byte(8'h7E, a2);
    in_valid = 1'b0;
    while (cyc < e0 + 35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (uart_tx !== 1'b1) begin
      errors++; $display("FAIL midrst_tx: got %b want 1", uart_tx);
    end
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL midrst_count: got %0d want 0", fifo_count);
    end
    if (tx_done !== 1'b0) begin
      errors++; $display("FAIL midrst_done: got %b want 0", tx_done);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got %b want 0", busy);
    end
    rst  = 1'b0;
    d0   = dones;
    f0   = frames;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    checks += 4;
    if (lows != 0) begin
      errors++; $display("FAIL midrst_line: got %0d low cycles want 0", lows);
    end
    if (dones != d0) begin
      errors++; $display("FAIL midrst_nodone: got %0d pulses want 0", dones - d0);
    end
    if (frames != f0) begin
      errors++; $display("FAIL midrst_noframe: got %0d frames want 0", frames - f0);
    end
    if (fifo_count !== 3'd0) begin
      errors++; $display("FAIL midrst_count2: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_stall_hold;
    int p0, a, t, d0, f0;
    wait_idle(t);
    n99 = 0;
    d0  = dones;
    f0  = frames;
    push_byte(8'h11, p0);
    for (int i = 1; i < 5; i++) push_byte(8'h11 * 8'(i + 1), a);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_full: got in_ready=%b want 0", in_ready);
    end
    push_byte(8'h99, a);
    in_valid = 1'b0;
    checks++;
    if (a != p0 + 82) begin
      errors++; $display("FAIL stall_accept: got %0d want %0d", a, p0 + 82);
    end
    wait_idle(t);
    checks += 4;
    if (n99 != 1) begin
      errors++; $display("FAIL stall_once: got %0d accepts want 1", n99);
    end
    if (frames - f0 != 6) begin
      errors++; $display("FAIL stall_frames: got %0d want 6", frames - f0);
    end
    if (dones - d0 != 6) begin
      errors++; $display("FAIL stall_dones: got %0d want 6", dones - d0);
    end
    if (sb.size() != 0) begin
      errors++; $display("FAIL stall_sb: got %0d left want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_reset_midframe();
    test_stall_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
